// File: rtl/fsmd_pkg.sv
// Shared types for the fsmd register-bank/ALU datapath and its controllers:
// register names, bus-D source, ALU function, GCD controller states and the
// control word that drives the datapath.
package fsmd_pkg;

    typedef enum logic [2:0] {R0, R1, R2, R3, R4, R5, R6, R7} reg_t;

    typedef enum logic {ALU, EXT} dsel_t;

    typedef enum logic [2:0] {PASSA, ADD, SUB, ANDF, ORF, XORF, NOTA, PASSB} fsel_t;

    typedef enum logic [3:0] {
        IDLE, LOAD_B, CHK_A, CHK_B, CMP, SUB_AB, SUB_BA, RES_B, DONE, ERR
    } ctrl_state_t;

    typedef struct packed {
        logic  we;
        reg_t  rsel;
        reg_t  asel;
        reg_t  bsel;
        dsel_t dsel;
        fsel_t fsel;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '{we: 1'b0, rsel: R0, asel: R0, bsel: R0,
                                        dsel: ALU, fsel: PASSA};

    // Moore control word for each controller state
    function automatic ctrl_word_t ctrl_decode(input ctrl_state_t s);
        ctrl_word_t cw;
        cw = CTRL_NOP;
        case (s)
            CHK_A:  cw.asel = R1;
            CHK_B:  cw.asel = R2;
            CMP: begin
                cw.asel = R1;
                cw.bsel = R2;
                cw.fsel = SUB;
            end
            SUB_AB: begin
                cw.we   = 1'b1;
                cw.rsel = R1;
                cw.asel = R1;
                cw.bsel = R2;
                cw.fsel = SUB;
            end
            SUB_BA: begin
                cw.we   = 1'b1;
                cw.rsel = R2;
                cw.asel = R2;
                cw.bsel = R1;
                cw.fsel = SUB;
            end
            RES_B: begin
                cw.we   = 1'b1;
                cw.rsel = R1;
                cw.asel = R2;
            end
            DONE:   cw.asel = R1;
            default: ;
        endcase
        return cw;
    endfunction

endpackage

// File: rtl/fsmd_gcd_ctrl.sv
// GCD controller for the fsmd datapath: loads A into R1 and B into R2 over a
// valid/ready handshake, then reduces them by repeated subtraction until they
// match. Result is presented on busa (R1) with a one-cycle done pulse;
// out-of-range operands or an overlong loop produce a one-cycle err pulse.
module fsmd_gcd_ctrl
    import fsmd_pkg::*;
#(
    parameter int unsigned W        = 16,
    parameter int unsigned MAX_ITER = 4095
) (
    input  logic  clk,
    input  logic  arst,
    input  logic  valid_in,
    input  logic  ext_msb_in,
    input  logic  z_in,
    input  logic  n_in,
    output logic  ready_out,
    output logic  done_out,
    output logic  err_out,
    output logic  we_out,
    output reg_t  rsel_out,
    output reg_t  asel_out,
    output reg_t  bsel_out,
    output dsel_t dsel_out,
    output fsel_t fsel_out
);

    localparam int unsigned ITER_W = $clog2(MAX_ITER + 1);

    if (W < 2) begin : g_width_check
        $error("fsmd_gcd_ctrl: W must be at least 2");
    end

    ctrl_state_t       state_r;
    ctrl_state_t       next_state;
    logic [ITER_W-1:0] iter;
    ctrl_word_t        ctrl_r;
    ctrl_word_t        ctrl_out;
    logic              ready_r;
    logic              done_r;
    logic              err_r;
    logic              load;

    assign load = ready_r & valid_in & ~ext_msb_in;

    // Next state from the current state and the flags of this cycle's ALU result
    always_comb begin
        next_state = state_r;
        case (state_r)
            IDLE:   if (valid_in) next_state = ext_msb_in ? ERR : LOAD_B;
            LOAD_B: if (valid_in) next_state = ext_msb_in ? ERR : CHK_A;
            CHK_A:  next_state = z_in ? RES_B : CHK_B;
            CHK_B:  next_state = z_in ? DONE : CMP;
            CMP: begin
                if (iter == ITER_W'(MAX_ITER)) next_state = ERR;
                else if (z_in)                 next_state = DONE;
                else if (n_in)                 next_state = SUB_BA;
                else                           next_state = SUB_AB;
            end
            SUB_AB, SUB_BA: next_state = CMP;
            RES_B:          next_state = DONE;
            DONE, ERR:      next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    // State, iteration count and registered control outputs (decoded from next_state)
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= IDLE;
            iter    <= '0;
            ctrl_r  <= CTRL_NOP;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state;
            ctrl_r  <= ctrl_decode(next_state);
            ready_r <= (next_state == IDLE) || (next_state == LOAD_B);
            done_r  <= (next_state == DONE);
            err_r   <= (next_state == ERR);
            if (state_r == SUB_AB || state_r == SUB_BA)
                iter <= iter + 1'b1;
            else if (state_r == DONE || state_r == ERR)
                iter <= '0;
        end
    end

    // Operand load is qualified by the handshake in the same cycle, so the
    // idle control word stays a no-op and rejected operands never reach a register
    always_comb begin
        ctrl_out = ctrl_r;
        if (load) begin
            ctrl_out.we   = 1'b1;
            ctrl_out.rsel = (state_r == LOAD_B) ? R2 : R1;
            ctrl_out.dsel = EXT;
        end
    end

    assign ready_out = ready_r;
    assign done_out  = done_r;
    assign err_out   = err_r;
    assign we_out    = ctrl_out.we;
    assign rsel_out  = ctrl_out.rsel;
    assign asel_out  = ctrl_out.asel;
    assign bsel_out  = ctrl_out.bsel;
    assign dsel_out  = ctrl_out.dsel;
    assign fsel_out  = ctrl_out.fsel;

endmodule

// File: tb/tb_fsmd_gcd_ctrl.sv
// Bench for fsmd_gcd_ctrl: a small register-bank/ALU datapath model surrounds
// the controller; each run's outcome, result, latency and write count are
// compared against a Euclid-based reference computed with division/modulo.
module tb_fsmd_gcd_ctrl;
    import fsmd_pkg::*;

    localparam int unsigned W        = 16;
    localparam int unsigned MAX_ITER = 16;

    logic         clk = 1'b0;
    logic         arst;
    logic         valid_in;
    logic [W-1:0] ext_in;
    logic         z, n;
    logic         ready_out, done_out, err_out, we_out;
    reg_t         rsel_out, asel_out, bsel_out;
    dsel_t        dsel_out;
    fsel_t        fsel_out;

    logic [W-1:0] rf [8] = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03,
                             16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07};
    logic [W-1:0] busa, busb, alu, busd;

    int vectors     = 0;
    int miscompares = 0;
    int bad_tgt     = 0;

    always #5 clk = ~clk;

    fsmd_gcd_ctrl #(.W(W), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .arst(arst), .valid_in(valid_in), .ext_msb_in(ext_in[W-1]),
        .z_in(z), .n_in(n), .ready_out(ready_out), .done_out(done_out),
        .err_out(err_out), .we_out(we_out), .rsel_out(rsel_out),
        .asel_out(asel_out), .bsel_out(bsel_out), .dsel_out(dsel_out),
        .fsel_out(fsel_out)
    );

    // Datapath model: register bank, ALU and flags
    always_comb begin
        busa = rf[asel_out];
        busb = rf[bsel_out];
        case (fsel_out)
            PASSA:   alu = busa;
            ADD:     alu = busa + busb;
            SUB:     alu = busa - busb;
            ANDF:    alu = busa & busb;
            ORF:     alu = busa | busb;
            XORF:    alu = busa ^ busb;
            NOTA:    alu = ~busa;
            PASSB:   alu = busb;
            default: alu = busa;
        endcase
        busd = (dsel_out == EXT) ? ext_in : alu;
        z    = (alu == '0);
        n    = alu[W-1];
    end

    always @(posedge clk) begin
        if (we_out) rf[rsel_out] <= busd;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: GCD via Euclid; subtraction count is the sum of quotients minus one
    task automatic ref_model(input int unsigned a, input int unsigned b,
                             output int unsigned res, output bit err,
                             output int unsigned lat, output int unsigned writes);
        int unsigned x, y, t, qsum, subs;
        err = 1'b0;
        if (a == 0) begin
            res = b; lat = 2; writes = 1;
        end else if (b == 0) begin
            res = a; lat = 2; writes = 0;
        end else begin
            x = a; y = b; qsum = 0;
            while (y != 0) begin
                qsum += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            res  = x;
            subs = qsum - 1;
            if (subs >= MAX_ITER) begin
                err = 1'b1; lat = 3 + 2 * MAX_ITER; writes = MAX_ITER;
            end else begin
                lat = 3 + 2 * subs; writes = subs;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready_out, 1);
        chk({tag, "_done"},  done_out, 0);
        chk({tag, "_err"},   err_out, 0);
        chk({tag, "_we"},    we_out, 0);
        chk({tag, "_rsel"},  rsel_out, R0);
        chk({tag, "_asel"},  asel_out, R0);
        chk({tag, "_bsel"},  bsel_out, R0);
        chk({tag, "_dsel"},  dsel_out, ALU);
        chk({tag, "_fsel"},  fsel_out, PASSA);
    endtask

    task automatic expect_range_err(input string tag);
        chk({tag, "_we"}, we_out, 0);
        @(negedge clk);
        valid_in = 1'b0;
        chk({tag, "_err"}, err_out, 1);
        chk({tag, "_ready"}, ready_out, 0);
        @(negedge clk);
        chk({tag, "_err_pulse"}, err_out, 0);
        chk({tag, "_ready_back"}, ready_out, 1);
    endtask

    task automatic run_gcd(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned gap);
        int unsigned exp_res, lat, writes, cyc, wr, rdy;
        bit          exp_err;
        logic [W-1:0] r1_keep;
        @(negedge clk);
        chk("ready_idle", ready_out, 1);
        r1_keep  = rf[1];
        ext_in   = a;
        valid_in = 1'b1;
        #1;
        if (a[W-1]) begin
            expect_range_err("range_a");
            chk("range_a_r1_kept", rf[1], r1_keep);
            return;
        end
        chk("load_a_we", we_out, 1);
        chk("load_a_rsel", rsel_out, R1);
        chk("load_a_dsel", dsel_out, EXT);
        @(negedge clk);
        for (int i = 0; i < int'(gap); i++) begin
            valid_in = 1'b0;
            #1;
            chk("hold_ready", ready_out, 1);
            chk("hold_we", we_out, 0);
            @(negedge clk);
        end
        ext_in   = b;
        valid_in = 1'b1;
        #1;
        if (b[W-1]) begin
            expect_range_err("range_b");
            chk("range_b_r1_kept", rf[1], a);
            return;
        end
        chk("load_b_we", we_out, 1);
        chk("load_b_rsel", rsel_out, R2);
        @(negedge clk);
        valid_in = 1'b0;
        ext_in   = W'($urandom);
        #1;
        ref_model(a, b, exp_res, exp_err, lat, writes);
        cyc = 0; wr = 0; rdy = 0;
        while (!(done_out || err_out) && cyc <= lat + 8) begin
            if (we_out) wr++;
            if (ready_out) rdy++;
            if (we_out && rsel_out != R1 && rsel_out != R2) bad_tgt++;
            @(negedge clk);
            cyc++;
        end
        chk("outcome_err", err_out, exp_err);
        chk("outcome_done", done_out, !exp_err);
        chk("latency", cyc, lat);
        if (!exp_err) chk("result", busa, exp_res);
        chk("writes", wr, writes);
        chk("ready_busy", rdy, 0);
        @(negedge clk);
        chk("pulse_clear", done_out | err_out, 0);
        chk("ready_after", ready_out, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arst     = 1'b1;
        valid_in = 1'b0;
        ext_in   = '0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        arst = 1'b0;

        run_gcd(16'd48, 16'd18, 0);
        run_gcd(16'd0,  16'd7,  0);
        run_gcd(16'd7,  16'd0,  1);
        run_gcd(16'd0,  16'd0,  0);
        run_gcd(16'd5,  16'd5,  0);
        run_gcd(16'h8000, 16'd3, 0);
        run_gcd(16'd1,  16'd32767, 0);
        run_gcd(16'd9,  16'd6,  3);
        run_gcd(16'd5,  16'h8001, 1);

        for (int i = 0; i < 40; i++) begin
            int unsigned mode;
            logic [W-1:0] a, b;
            mode = $urandom_range(0, 9);
            if (mode < 6) begin
                a = W'($urandom_range(0, 60));
                b = W'($urandom_range(0, 60));
            end else begin
                a = W'($urandom_range(0, 32767));
                b = W'($urandom_range(0, 32767));
            end
            if (mode == 8) a = a | 16'h8000;
            if (mode == 9) b = b | 16'h8000;
            run_gcd(a, b, $urandom_range(0, 2));
        end

        // Reset in the middle of a long subtraction loop
        @(negedge clk);
        ext_in = 16'd1; valid_in = 1'b1;
        @(negedge clk);
        ext_in = 16'd32767;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (6) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        chk_reset_outputs("midrun_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrun_no_done", done_out, 0);
            chk("midrun_no_err", err_out, 0);
        end
        arst = 1'b0;
        run_gcd(16'd12, 16'd8, 0);

        chk("we_target_r1_r2_only", bad_tgt, 0);
        for (int i = 0; i < 8; i++) begin
            if (i != 1 && i != 2)
                chk($sformatf("r%0d_untouched", i), rf[i], 16'h0A00 + 16'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
